// File: rtl/bus_src_arbiter_pkg.sv
// Shared definitions for the bus-source arbiter: default geometry,
// legal-source mask and the FSM state encoding.
package bus_src_arbiter_pkg;

  localparam int          N_SRC_DEF    = 32;
  localparam logic [31:0] SRC_MASK_DEF = 32'h00FF_FFFF;
  localparam int          IDX_W_DEF    = $clog2(N_SRC_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_src_arbiter_rr_pick.sv
// Round-robin winner select: lowest set bit at or above rr_ptr, otherwise
// wrap around to the lowest set bit overall.
module rr_pick #(
  parameter int N_SRC = 32,
  parameter int IW    = 5
) (
  input  logic [N_SRC-1:0] pending,
  input  logic [IW-1:0]    rr_ptr,
  output logic [IW-1:0]    idx,
  output logic             found
);

  logic          w_hi_found;
  logic [IW-1:0] w_hi_idx;
  logic          w_lo_found;
  logic [IW-1:0] w_lo_idx;

  // Scan downwards so the last hit recorded is the lowest qualifying index.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pending[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = IW'(i);
        if (i >= int'(rr_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IW'(i);
        end
      end
    end
    found = w_lo_found;
    idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  end

endmodule

// File: rtl/bus_src_arbiter.sv
// Serialises a batch of bus-drive requests into a one-hot-per-cycle grant
// for the bus encoder, round-robin across batches, with a datapath stall.
module bus_src_arbiter
  import bus_src_arbiter_pkg::*;
#(
  parameter int               N_SRC    = N_SRC_DEF,
  parameter logic [N_SRC-1:0] SRC_MASK = SRC_MASK_DEF,
  parameter int               HOLD_CYC = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req_valid,
  input  logic [N_SRC-1:0] req_mask,
  output logic             req_ready,
  input  logic             hold,
  output logic [N_SRC-1:0] grant,
  output logic             grant_valid,
  output logic             grant_last,
  output logic             batch_done,
  output logic             err_drop
);

  localparam int               IW       = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int               CNT_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);

  arb_state_e       r_state;
  logic [N_SRC-1:0] r_pending;
  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_cur;
  logic [CNT_W-1:0] r_cnt;
  logic [N_SRC-1:0] r_grant;
  logic             r_grant_valid;
  logic             r_grant_last;
  logic             r_batch_done;
  logic             r_err_drop;

  logic [N_SRC-1:0] w_req_legal;
  logic             w_req_bad;
  logic [N_SRC-1:0] w_cur_oh;
  logic [N_SRC-1:0] w_pend_clr;
  logic [IW-1:0]    w_cur_inc;
  logic [N_SRC-1:0] w_pick_pend;
  logic [IW-1:0]    w_pick_ptr;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_found;
  logic [N_SRC-1:0] w_pick_oh;

  function automatic logic [N_SRC-1:0] onehot(input logic [IW-1:0] i);
    return {{(N_SRC-1){1'b0}}, 1'b1} << i;
  endfunction

  assign w_req_legal = req_mask & SRC_MASK;
  assign w_req_bad   = |(req_mask & ~SRC_MASK);
  assign w_cur_oh    = onehot(r_cur);
  assign w_pend_clr  = r_pending & ~w_cur_oh;
  assign w_cur_inc   = (r_cur == IW'(N_SRC - 1)) ? '0 : r_cur + IW'(1);

  // One picker serves both the first winner of a new batch and the next
  // winner after a grant retires; the state selects which operands it sees.
  assign w_pick_pend = (r_state == ST_IDLE) ? w_req_legal : w_pend_clr;
  assign w_pick_ptr  = (r_state == ST_IDLE) ? r_rr_ptr    : w_cur_inc;
  assign w_pick_oh   = onehot(w_pick_idx);

  rr_pick #(
    .N_SRC (N_SRC),
    .IW    (IW)
  ) u_rr_pick (
    .pending (w_pick_pend),
    .rr_ptr  (w_pick_ptr),
    .idx     (w_pick_idx),
    .found   (w_pick_found)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state       <= ST_IDLE;
      r_pending     <= '0;
      r_rr_ptr      <= '0;
      r_cur         <= '0;
      r_cnt         <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_last  <= 1'b0;
      r_batch_done  <= 1'b0;
      r_err_drop    <= 1'b0;
    end else begin
      r_batch_done <= 1'b0;
      r_err_drop   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_err_drop <= w_req_bad;
            r_pending  <= w_req_legal;
            if (w_pick_found) begin
              r_state       <= ST_GRANT;
              r_cur         <= w_pick_idx;
              r_grant       <= w_pick_oh;
              r_grant_valid <= 1'b1;
              r_grant_last  <= (w_req_legal == w_pick_oh);
              r_cnt         <= CNT_LOAD;
            end else begin
              r_state      <= ST_DONE;
              r_batch_done <= 1'b1;
            end
          end
        end
        ST_GRANT: begin
          if (!hold) begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CNT_W'(1);
            end else begin
              r_pending <= w_pend_clr;
              r_rr_ptr  <= w_cur_inc;
              if (w_pick_found) begin
                r_cur        <= w_pick_idx;
                r_grant      <= w_pick_oh;
                r_grant_last <= (w_pend_clr == w_pick_oh);
                r_cnt        <= CNT_LOAD;
              end else begin
                r_state       <= ST_DONE;
                r_grant       <= '0;
                r_grant_valid <= 1'b0;
                r_grant_last  <= 1'b0;
                r_batch_done  <= 1'b1;
              end
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_last  = r_grant_last;
  assign batch_done  = r_batch_done;
  assign err_drop    = r_err_drop;

endmodule

// File: tb/tb_bus_src_arbiter.sv
// Directed bench for bus_src_arbiter: one instance with single-cycle grants,
// one with three-cycle grants, sharing clock and reset.
module tb_bus_src_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic        rv1, h1, rdy1, gv1, gl1, bd1, ed1;
  logic [31:0] m1, g1;
  logic        rv3, h3, rdy3, gv3, gl3, bd3, ed3;
  logic [31:0] m3, g3;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_src_arbiter #(.HOLD_CYC(1)) dut1 (
    .clk(clk), .clr(clr), .req_valid(rv1), .req_mask(m1), .req_ready(rdy1),
    .hold(h1), .grant(g1), .grant_valid(gv1), .grant_last(gl1),
    .batch_done(bd1), .err_drop(ed1)
  );

  bus_src_arbiter #(.HOLD_CYC(3)) dut3 (
    .clk(clk), .clr(clr), .req_valid(rv3), .req_mask(m3), .req_ready(rdy3),
    .hold(h3), .grant(g3), .grant_valid(gv3), .grant_last(gl3),
    .batch_done(bd3), .err_drop(ed3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic c1(input string tag, input logic [31:0] g, input logic gv, input logic gl,
                    input logic bd, input logic ed, input logic rdy);
    chk({tag, ".grant"}, g1, g);
    chk({tag, ".grant_valid"}, 32'(gv1), 32'(gv));
    chk({tag, ".grant_last"}, 32'(gl1), 32'(gl));
    chk({tag, ".batch_done"}, 32'(bd1), 32'(bd));
    chk({tag, ".err_drop"}, 32'(ed1), 32'(ed));
    chk({tag, ".req_ready"}, 32'(rdy1), 32'(rdy));
  endtask

  task automatic c3(input string tag, input logic [31:0] g, input logic gv, input logic gl,
                    input logic bd, input logic ed, input logic rdy);
    chk({tag, ".grant"}, g3, g);
    chk({tag, ".grant_valid"}, 32'(gv3), 32'(gv));
    chk({tag, ".grant_last"}, 32'(gl3), 32'(gl));
    chk({tag, ".batch_done"}, 32'(bd3), 32'(bd));
    chk({tag, ".err_drop"}, 32'(ed3), 32'(ed));
    chk({tag, ".req_ready"}, 32'(rdy3), 32'(rdy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant must be one-hot-or-zero and stay inside the decodable sources.
  always @(negedge clk) begin
    if (clr === 1'b1) begin
      n_chk++;
      assert ($onehot0(g1) && $onehot0(g3) && (((g1 | g3) & 32'hFF00_0000) == 32'h0)) else begin
        n_err++;
        $error("FAIL invariant: observed g1=%h g3=%h expected onehot0 within 00FFFFFF", g1, g3);
      end
    end
  end

  initial begin
    clr = 1'b0;
    rv1 = 1'b0; m1 = '0; h1 = 1'b0;
    rv3 = 1'b0; m3 = '0; h3 = 1'b0;
    tick(); tick();
    c1("rst1", 32'h0, 0, 0, 0, 0, 1);
    c3("rst3", 32'h0, 0, 0, 0, 0, 1);
    clr = 1'b1;
    tick();

    // Three-source batch, back-to-back grants
    rv1 = 1'b1; m1 = 32'h15;
    tick(); c1("t2a", 32'h1,  1, 0, 0, 0, 0);
    rv1 = 1'b0; m1 = '0;
    tick(); c1("t2b", 32'h4,  1, 0, 0, 0, 0);
    tick(); c1("t2c", 32'h10, 1, 1, 0, 0, 0);
    tick(); c1("t2d", 32'h0,  0, 0, 1, 0, 0);
    tick(); c1("t2e", 32'h0,  0, 0, 0, 0, 1);

    // Round robin continues from rr_ptr=5
    rv1 = 1'b1; m1 = 32'h21;
    tick(); c1("t3a", 32'h20, 1, 0, 0, 0, 0);
    rv1 = 1'b0; m1 = '0;
    tick(); c1("t3b", 32'h1,  1, 1, 0, 0, 0);
    tick(); c1("t3c", 32'h0,  0, 0, 1, 0, 0);
    tick(); c1("t3d", 32'h0,  0, 0, 0, 0, 1);

    // Stall while 0x4 is granted
    rv1 = 1'b1; m1 = 32'hC;
    tick(); c1("t4a", 32'h4, 1, 0, 0, 0, 0);
    rv1 = 1'b0; m1 = '0; h1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); c1("t4h", 32'h4, 1, 0, 0, 0, 0);
      chk("t4h.pending", dut1.r_pending, 32'hC);
      chk("t4h.rr_ptr", 32'(dut1.r_rr_ptr), 32'd1);
    end
    h1 = 1'b0;
    tick(); c1("t4b", 32'h8, 1, 1, 0, 0, 0);
    tick(); c1("t4c", 32'h0, 0, 0, 1, 0, 0);
    chk("t4c.rr_ptr", 32'(dut1.r_rr_ptr), 32'd4);
    tick(); c1("t4d", 32'h0, 0, 0, 0, 0, 1);

    // Illegal bits dropped, then an empty batch
    rv1 = 1'b1; m1 = 32'hFF00_0002;
    tick(); c1("t5a", 32'h2, 1, 1, 0, 1, 0);
    rv1 = 1'b0; m1 = '0;
    tick(); c1("t5b", 32'h0, 0, 0, 1, 0, 0);
    tick(); c1("t5c", 32'h0, 0, 0, 0, 0, 1);
    rv1 = 1'b1; m1 = 32'h0;
    tick(); c1("t5d", 32'h0, 0, 0, 1, 0, 0);
    rv1 = 1'b0;
    tick(); c1("t5e", 32'h0, 0, 0, 0, 0, 1);

    // Three-cycle grants, requests during the batch ignored
    rv3 = 1'b1; m3 = 32'h0080_0001;
    tick(); c3("t6a", 32'h1, 1, 0, 0, 0, 0);
    m3 = 32'h0000_00FF;
    tick(); c3("t6b", 32'h1, 1, 0, 0, 0, 0);
    tick(); c3("t6c", 32'h1, 1, 0, 0, 0, 0);
    tick(); c3("t6d", 32'h0080_0000, 1, 1, 0, 0, 0);
    tick(); c3("t6e", 32'h0080_0000, 1, 1, 0, 0, 0);
    tick(); c3("t6f", 32'h0080_0000, 1, 1, 0, 0, 0);
    tick(); c3("t6g", 32'h0, 0, 0, 1, 0, 0);
    rv3 = 1'b0; m3 = '0;
    tick(); c3("t6h", 32'h0, 0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a batch
    rv1 = 1'b1; m1 = 32'h6;
    tick(); c1("t1a", 32'h4, 1, 0, 0, 0, 0);
    rv1 = 1'b0; m1 = '0;
    clr = 1'b0;
    #1; c1("t1b", 32'h0, 0, 0, 0, 0, 1);
    tick(); c1("t1c", 32'h0, 0, 0, 0, 0, 1);
    clr = 1'b1;
    tick(); c1("t1d", 32'h0, 0, 0, 0, 0, 1);
    rv1 = 1'b1; m1 = 32'h21;
    tick(); c1("t1e", 32'h1,  1, 0, 0, 0, 0);
    rv1 = 1'b0; m1 = '0;
    tick(); c1("t1f", 32'h20, 1, 1, 0, 0, 0);
    tick(); c1("t1g", 32'h0,  0, 0, 1, 0, 0);
    tick(); c1("t1h", 32'h0,  0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
